// File: rtl/iter_multiplier_if.sv
// Operand/result handshake bundle for iter_multiplier.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : multiplier side (drives in_ready, out_valid and the product)
// Signals:
//   in_valid/in_ready   operand handshake
//   x, y                multiplicand / multiplier, WIDTH bits
//   is_signed           1 = two's-complement operands, 0 = unsigned
//   out_valid/out_ready result handshake
//   p                   product, 2*WIDTH bits
interface iter_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes.
// Retires STEP_BITS multiplier bits per RUN cycle, so a product takes
// N = WIDTH/STEP_BITS RUN cycles. Supports unsigned and two's-complement
// operands chosen per transaction.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    iter_multiplier_if slave (operands in, product out)
//   busy   high while iterating (RUN)
module iter_multiplier #(
  parameter int WIDTH     = 8,
  parameter int STEP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  iter_multiplier_if.slave   bus,
  output logic               busy
);

  localparam int N     = WIDTH / STEP_BITS;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || STEP_BITS < 1 || (WIDTH % STEP_BITS) != 0) begin : g_bad_params
      $error("iter_multiplier: WIDTH must be >= 2 and a multiple of STEP_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    accept;
  logic                    last;
  logic                    top_neg;
  logic signed [PW-1:0]    mcand;
  logic signed [PW-1:0]    acc;
  logic signed [PW-1:0]    sum;
  logic signed [PW-1:0]    p_r;
  logic [WIDTH-1:0]        mplier;
  logic                    sgn;
  logic [CNT_W-1:0]        cnt;

  function automatic logic signed [PW-1:0] sign_ext(input logic [WIDTH-1:0] v,
                                                    input logic             s);
    logic signed [PW-1:0] r;
    r = {{WIDTH{s & v[WIDTH-1]}}, v};
    return r;
  endfunction

  // Sum of the (already position-shifted) multiplicand for each set bit of
  // the slice. In signed mode the multiplier's MSB carries weight -2^(W-1)
  // rather than +2^(W-1); the correction is subtracting x_ext*2^W, which on
  // the last slice is exactly mc shifted by one more slice width.
  function automatic logic signed [PW-1:0] partial_product(
    input logic signed [PW-1:0] mc,
    input logic [STEP_BITS-1:0] sl,
    input logic                 neg
  );
    logic signed [PW-1:0] r;
    r = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (sl[i]) r = r + (mc <<< i);
    end
    if (neg) r = r - (mc <<< STEP_BITS);
    return r;
  endfunction

  assign accept  = bus.in_valid && bus.in_ready;
  assign last    = (cnt == '0);
  assign top_neg = last && sgn && mplier[STEP_BITS-1];
  assign sum     = acc + partial_product(mcand, mplier[STEP_BITS-1:0], top_neg);
  assign bus.p   = p_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Back-to-back: a new operand set is taken on the same edge the
        // consumer takes the result.
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) state_nx = bus.in_valid ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accept stage: latch operands; RUN stage: one slice per edge, multiplicand
  // moves left and multiplier moves right so the low slice is always next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      sgn    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      p_r    <= '0;
    end else if (accept) begin
      mcand  <= sign_ext(bus.x, bus.is_signed);
      mplier <= bus.y;
      sgn    <= bus.is_signed;
      acc    <= '0;
      cnt    <= CNT_W'(N - 1);
    end else if (state == RUN) begin
      mcand  <= mcand <<< STEP_BITS;
      mplier <= mplier >> STEP_BITS;
      cnt    <= cnt - 1'b1;
      acc    <= sum;
      if (last) p_r <= sum;
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier: a WIDTH=8/STEP_BITS=1 instance
// (index 0) and a WIDTH=8/STEP_BITS=2 instance (index 1).
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv  [2];
  logic        sg  [2];
  logic        orr [2];
  logic [7:0]  xs  [2];
  logic [7:0]  ys  [2];
  logic        ir  [2];
  logic        ov  [2];
  logic        bz  [2];
  logic [15:0] pp  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_multiplier_if #(.WIDTH(8)) bus0 ();
  iter_multiplier_if #(.WIDTH(8)) bus1 ();

  assign bus0.in_valid  = iv[0];
  assign bus0.x         = xs[0];
  assign bus0.y         = ys[0];
  assign bus0.is_signed = sg[0];
  assign bus0.out_ready = orr[0];
  assign ir[0] = bus0.in_ready;
  assign ov[0] = bus0.out_valid;
  assign pp[0] = bus0.p;

  assign bus1.in_valid  = iv[1];
  assign bus1.x         = xs[1];
  assign bus1.y         = ys[1];
  assign bus1.is_signed = sg[1];
  assign bus1.out_ready = orr[1];
  assign ir[1] = bus1.in_ready;
  assign ov[1] = bus1.out_valid;
  assign pp[1] = bus1.p;

  iter_multiplier #(.WIDTH(8), .STEP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(bz[0])
  );

  iter_multiplier #(.WIDTH(8), .STEP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(bz[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
    end
    return {8'd0, a} * {8'd0, b};
  endfunction

  // One full transaction: accept, latency/busy count, optional stall, handoff.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] expv, input int n,
                        input int stall, input string name);
    int w, lat, bcnt;
    iv[sel] = 1'b1; xs[sel] = a; ys[sel] = b; sg[sel] = s;
    w = 0;
    while (ir[sel] !== 1'b1 && w < 50) begin tick; w++; end
    n_cmp++;
    if (ir[sel] !== 1'b1) begin
      n_err++; $display("FAIL %s_accept: in_ready=%b required 1", name, ir[sel]);
    end
    tick;
    // Scramble inputs after the accept edge; they must have no effect.
    iv[sel] = 1'b0; xs[sel] = ~a; ys[sel] = ~b; sg[sel] = ~s;
    lat = 0; bcnt = 0;
    while (ov[sel] !== 1'b1 && lat < 50) begin
      if (bz[sel] === 1'b1) bcnt++;
      tick; lat++;
    end
    n_cmp++;
    if (lat !== n) begin
      n_err++; $display("FAIL %s_latency: got %0d required %0d", name, lat, n);
    end
    n_cmp++;
    if (bcnt !== n) begin
      n_err++; $display("FAIL %s_busy: got %0d cycles required %0d", name, bcnt, n);
    end
    n_cmp++;
    if (pp[sel] !== expv) begin
      n_err++; $display("FAIL %s_p: got %h required %h", name, pp[sel], expv);
    end
    orr[sel] = 1'b0;
    for (int k = 0; k < stall; k++) tick;
    n_cmp++;
    if (ov[sel] !== 1'b1 || pp[sel] !== expv) begin
      n_err++;
      $display("FAIL %s_hold: out_valid=%b p=%h required 1/%h", name, ov[sel], pp[sel], expv);
    end
    orr[sel] = 1'b1;
    tick;
    orr[sel] = 1'b0;
    n_cmp++;
    if (ov[sel] !== 1'b0) begin
      n_err++; $display("FAIL %s_handoff: out_valid=%b required 0", name, ov[sel]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ov[i] !== 1'b0 || bz[i] !== 1'b0 || pp[i] !== 16'h0 || ir[i] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_%0d: ov=%b busy=%b p=%h in_ready=%b required 0/0/0000/1",
                 i, ov[i], bz[i], pp[i], ir[i]);
      end
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_unsigned;
    run_op(0, 8'd255, 8'd255, 1'b0, 16'hFE01, 8, 0, "u255x255");
    run_op(1, 8'd200, 8'd150, 1'b0, 16'h7530, 4, 0, "s2_200x150");
    run_op(1, 8'd255, 8'd255, 1'b0, 16'hFE01, 4, 1, "s2_255x255");
  endtask

  task automatic test_signed;
    run_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "sm128xm128");
    run_op(0, 8'hFF, 8'h7F, 1'b1, 16'hFF81, 8, 0, "sm1x127");
    run_op(0, 8'h00, 8'hFB, 1'b1, 16'h0000, 8, 0, "s0xm5");
    run_op(1, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 4, 0, "s2_m3x5");
    run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, 4, 0, "s2_m128xm128");
    run_op(0, 8'h7F, 8'h80, 1'b1, 16'hC080, 8, 0, "s127xm128");
  endtask

  task automatic test_back_to_back;
    int w;
    iv[0] = 1'b1; xs[0] = 8'd12; ys[0] = 8'd11; sg[0] = 1'b0; orr[0] = 1'b0;
    tick;
    iv[0] = 1'b0;
    w = 0;
    while (ov[0] !== 1'b1 && w < 50) begin tick; w++; end
    // New operands offered while the result is back-pressured.
    xs[0] = 8'd3; ys[0] = 8'd7; iv[0] = 1'b1;
    repeat (5) tick;
    n_cmp++;
    if (pp[0] !== 16'h0084 || ov[0] !== 1'b1 || ir[0] !== 1'b0 || bz[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: p=%h ov=%b in_ready=%b busy=%b required 0084/1/0/0",
               pp[0], ov[0], ir[0], bz[0]);
    end
    orr[0] = 1'b1;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1) begin
      n_err++; $display("FAIL bp_in_ready: got %b required 1", ir[0]);
    end
    tick;
    iv[0] = 1'b0; orr[0] = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b1 || pp[0] !== 16'h0084) begin
      n_err++;
      $display("FAIL b2b_run: ov=%b busy=%b p=%h required 0/1/0084", ov[0], bz[0], pp[0]);
    end
    w = 0;
    while (ov[0] !== 1'b1 && w < 50) begin tick; w++; end
    n_cmp++;
    if (w !== 8 || pp[0] !== 16'h0015) begin
      n_err++; $display("FAIL b2b_result: latency=%0d p=%h required 8/0015", w, pp[0]);
    end
    orr[0] = 1'b1;
    tick;
    orr[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    iv[0] = 1'b1; xs[0] = 8'd9; ys[0] = 8'd9; sg[0] = 1'b0;
    tick;
    iv[0] = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || pp[0] !== 16'h0 || ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: ov=%b busy=%b p=%h in_ready=%b required 0/0/0000/1",
               ov[0], bz[0], pp[0], ir[0]);
    end
    tick;
    rst_n = 1'b1;
    tick;
    run_op(0, 8'd2, 8'd3, 1'b0, 16'h0006, 8, 0, "after_reset");
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic       s;
    for (int i = 0; i < 300; i++) begin
      for (int sel = 0; sel < 2; sel++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        s = 1'($urandom);
        run_op(sel, a, b, s, ref_mul(a, b, s), (sel == 0) ? 8 : 4,
               int'($urandom_range(0, 3)), "rand");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; sg[i] = 1'b0; orr[i] = 1'b0; xs[i] = '0; ys[i] = '0;
    end
    test_reset;
    test_unsigned;
    test_signed;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
